// File: rtl/audioport_pkg.sv
// Shared audioport constants and types: register-file layout of the sample
// buffers and the playback sequencer state encoding.
package audioport_pkg;

    localparam int unsigned RINDEX_BITS = 9;
    localparam logic [RINDEX_BITS-1:0] ABUF0_START_INDEX = 9'd192;
    localparam logic [RINDEX_BITS-1:0] ABUF1_START_INDEX = 9'd256;

    localparam int unsigned ABUF_SAMPLE_W = 24;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FETCH_L,
        FETCH_R
    } abuf_player_state_t;

endpackage

// File: rtl/abuf_player.sv
// Playback sequencer: drains ABUF0/ABUF1 one stereo pair per sample period,
// strobes the pair to dsp_unit and raises the buffer-swap interrupt.
module abuf_player
    import audioport_pkg::*;
#(
    parameter int unsigned AUDIO_BUFFER_SIZE = 32,
    parameter int unsigned DIV_W             = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     play_in,
    input  logic                     clr_in,
    input  logic                     irqack_in,
    input  logic [DIV_W-1:0]         clk_div_in,
    output logic [RINDEX_BITS-1:0]   abuf_rindex_out,
    input  logic [ABUF_SAMPLE_W-1:0] abuf_data_in,
    output logic                     tick_out,
    output logic [ABUF_SAMPLE_W-1:0] audio0_out,
    output logic [ABUF_SAMPLE_W-1:0] audio1_out,
    output logic                     irq_out,
    output logic                     irq_err_out
);

    localparam int unsigned IDX_W = (AUDIO_BUFFER_SIZE > 1) ? $clog2(AUDIO_BUFFER_SIZE) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(AUDIO_BUFFER_SIZE - 1);
    localparam logic [DIV_W-1:0] MIN_DIV  = DIV_W'(4);

    abuf_player_state_t       r_state, w_state_next;
    logic [DIV_W-1:0]         r_cnt, w_cnt_next;
    logic [IDX_W-1:0]         r_idx, w_idx_next;
    logic                     r_bsel, w_bsel_next;
    logic [ABUF_SAMPLE_W-1:0] r_left, w_left_next;
    logic [ABUF_SAMPLE_W-1:0] r_audio0, w_audio0_next;
    logic [ABUF_SAMPLE_W-1:0] r_audio1, w_audio1_next;
    logic                     r_tick, w_tick_next;
    logic                     r_irq, w_irq_next;
    logic                     r_irq_err, w_irq_err_next;
    logic                     w_swap;
    logic [DIV_W-1:0]         w_eff_div;
    logic [DIV_W-1:0]         w_reload;
    logic [RINDEX_BITS-1:0]   w_base;
    logic [RINDEX_BITS-1:0]   w_offs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_bsel    <= 1'b0;
            r_left    <= '0;
            r_audio0  <= '0;
            r_audio1  <= '0;
            r_tick    <= 1'b0;
            r_irq     <= 1'b0;
            r_irq_err <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_idx     <= w_idx_next;
            r_bsel    <= w_bsel_next;
            r_left    <= w_left_next;
            r_audio0  <= w_audio0_next;
            r_audio1  <= w_audio1_next;
            r_tick    <= w_tick_next;
            r_irq     <= w_irq_next;
            r_irq_err <= w_irq_err_next;
        end
    end

    always_comb begin
        w_eff_div      = (clk_div_in < MIN_DIV) ? MIN_DIV : clk_div_in;
        w_reload       = w_eff_div - DIV_W'(1);
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_idx_next     = r_idx;
        w_bsel_next    = r_bsel;
        w_left_next    = r_left;
        w_audio0_next  = r_audio0;
        w_audio1_next  = r_audio1;
        w_tick_next    = 1'b0;
        w_irq_next     = r_irq;
        w_irq_err_next = 1'b0;
        w_swap         = 1'b0;

        if (!play_in) begin
            w_state_next = IDLE;
        end else begin
            unique case (r_state)
                IDLE: begin
                    w_state_next = RUN;
                    w_cnt_next   = w_reload;
                end
                RUN: begin
                    if (r_cnt == '0) begin
                        w_cnt_next   = w_reload;
                        w_state_next = FETCH_L;
                    end else begin
                        w_cnt_next = r_cnt - DIV_W'(1);
                    end
                end
                // Divider keeps counting through both fetch cycles so the period stays exact.
                FETCH_L: begin
                    w_cnt_next   = r_cnt - DIV_W'(1);
                    w_left_next  = abuf_data_in;
                    w_state_next = FETCH_R;
                end
                FETCH_R: begin
                    w_cnt_next    = r_cnt - DIV_W'(1);
                    w_audio0_next = r_left;
                    w_audio1_next = abuf_data_in;
                    w_tick_next   = 1'b1;
                    w_state_next  = RUN;
                    if (r_idx == IDX_LAST) begin
                        w_idx_next  = '0;
                        w_bsel_next = ~r_bsel;
                        w_swap      = 1'b1;
                    end else begin
                        w_idx_next = r_idx + IDX_W'(1);
                    end
                end
            endcase
        end

        // A swap coinciding with an acknowledge keeps the interrupt and suppresses the error.
        if (w_swap) begin
            w_irq_next     = 1'b1;
            w_irq_err_next = r_irq & ~irqack_in;
        end else if (irqack_in) begin
            w_irq_next = 1'b0;
        end

        if (r_state == IDLE && clr_in) begin
            w_idx_next    = '0;
            w_bsel_next   = 1'b0;
            w_audio0_next = '0;
            w_audio1_next = '0;
            w_irq_next    = 1'b0;
        end
    end

    always_comb begin
        w_base          = r_bsel ? ABUF1_START_INDEX : ABUF0_START_INDEX;
        w_offs          = RINDEX_BITS'({r_idx, 1'b0});
        abuf_rindex_out = ABUF0_START_INDEX;
        case (r_state)
            FETCH_L: abuf_rindex_out = w_base + w_offs;
            FETCH_R: abuf_rindex_out = w_base + w_offs + RINDEX_BITS'(1);
            default: abuf_rindex_out = ABUF0_START_INDEX;
        endcase
    end

    assign tick_out    = r_tick;
    assign audio0_out  = r_audio0;
    assign audio1_out  = r_audio1;
    assign irq_out     = r_irq;
    assign irq_err_out = r_irq_err;

endmodule

// File: tb/tb_abuf_player.sv
// Scoreboard bench for abuf_player: stimulus pushes expected sample pairs and
// tick cycles, a negedge monitor pops and compares on every tick.
module tb_abuf_player;

    logic        clk;
    logic        rst_n;
    logic        play_in;
    logic        clr_in;
    logic        irqack_in;
    logic [31:0] clk_div_in;
    logic [8:0]  abuf_rindex_out;
    logic [23:0] abuf_data_in;
    logic        tick_out;
    logic [23:0] audio0_out;
    logic [23:0] audio1_out;
    logic        irq_out;
    logic        irq_err_out;

    abuf_player #(
        .AUDIO_BUFFER_SIZE(32),
        .DIV_W(32)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .play_in(play_in),
        .clr_in(clr_in),
        .irqack_in(irqack_in),
        .clk_div_in(clk_div_in),
        .abuf_rindex_out(abuf_rindex_out),
        .abuf_data_in(abuf_data_in),
        .tick_out(tick_out),
        .audio0_out(audio0_out),
        .audio1_out(audio1_out),
        .irq_out(irq_out),
        .irq_err_out(irq_err_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [23:0] mem [0:511];
    assign abuf_data_in = mem[abuf_rindex_out];

    typedef struct {
        logic [23:0] a0;
        logic [23:0] a1;
        logic        irq;
        logic        err;
        int          tcyc;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   m_idx, m_bsel;
    logic m_irq;

    function automatic logic [23:0] smp(input int b, input int i, input bit right);
        logic [23:0] base;
        if (b == 0) base = right ? 24'h800000 : 24'h000000;
        else        base = right ? 24'hC00000 : 24'h400000;
        return base + 24'(i);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Model n playback samples; ack_j* mark samples whose FETCH_R cycle carries irqack.
    task automatic push(input int n, input int c_e, input int d, input int ack_j0,
                        input int ack_j1);
        exp_t e;
        bit   ack;
        for (int j = 0; j < n; j++) begin
            ack    = (j == ack_j0) || (j == ack_j1);
            e.a0   = smp(m_bsel, m_idx, 1'b0);
            e.a1   = smp(m_bsel, m_idx, 1'b1);
            e.tcyc = c_e + d + 2 + j * d;
            if (m_idx == 31) begin
                e.err  = m_irq && !ack;
                m_irq  = 1'b1;
                m_bsel = 1 - m_bsel;
                m_idx  = 0;
            end else begin
                e.err = 1'b0;
                if (ack) m_irq = 1'b0;
                m_idx++;
            end
            e.irq = m_irq;
            sb.push_back(e);
        end
    endtask

    task automatic drain(input int ack_c0, input int ack_c1, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            irqack_in = (cyc == ack_c0) || (cyc == ack_c1);
            if (sb.size() == 0) break;
        end
        irqack_in = 1'b0;
        check("queue_drained", sb.size(), 0);
        sb.delete();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rindex"}, 32'(abuf_rindex_out), 32'd192);
        check({tag, "_tick"}, 32'(tick_out), 0);
        check({tag, "_audio0"}, 32'(audio0_out), 0);
        check({tag, "_audio1"}, 32'(audio1_out), 0);
        check({tag, "_irq"}, 32'(irq_out), 0);
        check({tag, "_irq_err"}, 32'(irq_err_out), 0);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n) begin
            if (irq_err_out) check("irq_err_with_tick", 32'(tick_out), 1);
            if (tick_out) begin
                check("tick_pending", 32'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("tick_cycle", cyc, e.tcyc);
                    check("audio0", 32'(audio0_out), 32'(e.a0));
                    check("audio1", 32'(audio1_out), 32'(e.a1));
                    check("irq", 32'(irq_out), 32'(e.irq));
                    check("irq_err", 32'(irq_err_out), 32'(e.err));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int c_e;
        int t66;
        for (int k = 0; k < 512; k++) mem[k] = 24'hBADBAD;
        for (int k = 0; k < 32; k++) begin
            mem[192 + 2 * k] = smp(0, k, 1'b0);
            mem[193 + 2 * k] = smp(0, k, 1'b1);
            mem[256 + 2 * k] = smp(1, k, 1'b0);
            mem[257 + 2 * k] = smp(1, k, 1'b1);
        end
        rst_n      = 1'b0;
        play_in    = 1'b0;
        clr_in     = 1'b0;
        irqack_in  = 1'b0;
        clk_div_in = 32'd6;
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Steady playback, buffer swap and unacknowledged second swap (divider 6).
        m_idx = 0; m_bsel = 0; m_irq = 1'b0;
        c_e = cyc + 1;
        push(64, c_e, 6, -1, -1);
        play_in = 1'b1;
        drain(-1, -1, 1200);
        play_in = 1'b0;
        repeat (4) @(negedge clk);
        check("stop_audio0_hold", 32'(audio0_out), 32'(smp(1, 31, 1'b0)));
        check("stop_audio1_hold", 32'(audio1_out), 32'(smp(1, 31, 1'b1)));
        check("stop_irq_hold", 32'(irq_out), 1);
        check("idle_rindex", 32'(abuf_rindex_out), 32'd192);

        clr_in = 1'b1;
        @(negedge clk);
        clr_in = 1'b0;
        check("clr_audio0", 32'(audio0_out), 0);
        check("clr_audio1", 32'(audio1_out), 0);
        check("clr_irq", 32'(irq_out), 0);

        // Clamped divider; ack coincides with second swap, then a plain ack.
        m_idx = 0; m_bsel = 0; m_irq = 1'b0;
        clk_div_in = 32'd2;
        @(negedge clk);
        c_e = cyc + 1;
        push(66, c_e, 4, 63, 64);
        play_in = 1'b1;
        drain(c_e + 6 + 63 * 4 - 1, c_e + 6 + 64 * 4 - 1, 1000);

        // Abandon the fetch of sample 66 while in FETCH_L.
        t66 = c_e + 6 + 66 * 4;
        for (int i = 0; i < 50 && cyc < t66 - 2; i++) @(negedge clk);
        check("fetch_l_rindex", 32'(abuf_rindex_out), 32'd196);
        play_in = 1'b0;
        repeat (8) @(negedge clk);
        check("abandon_audio0_hold", 32'(audio0_out), 32'(smp(0, 1, 1'b0)));
        check("abandon_audio1_hold", 32'(audio1_out), 32'(smp(0, 1, 1'b1)));
        check("abandon_irq_hold", 32'(irq_out), 0);
        clr_in = 1'b1;
        @(negedge clk);
        clr_in = 1'b0;
        check("clr2_audio0", 32'(audio0_out), 0);
        check("clr2_audio1", 32'(audio1_out), 0);

        // Restart after clear must read from ABUF0 index 0 again.
        m_idx = 0; m_bsel = 0; m_irq = 1'b0;
        @(negedge clk);
        c_e = cyc + 1;
        push(1, c_e, 4, -1, -1);
        play_in = 1'b1;
        drain(-1, -1, 100);

        // Asynchronous reset between clock edges while in RUN.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("async_reset");
        play_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/abuf_player.md
# abuf_player

Playback sequencer that drains the two APB-visible audio sample buffers (ABUF0 and ABUF1) at the configured sample rate. It delivers one stereo sample pair per sample period, with a one-cycle strobe, to the downstream `dsp_unit`. It sits between the register bank and `dsp_unit` inside `audioport`, and raises the buffer-swap interrupt that tells software to refill the buffer just emptied.

## Interface
Parameters:
- `AUDIO_BUFFER_SIZE`, default 32: stereo samples per buffer; each buffer spans 2×`AUDIO_BUFFER_SIZE` 24-bit registers.
- `DIV_W`, default 32: width of the clock-divider value.

Ports:
- `clk`  in  1: system clock; sole clock domain.
- `rst_n`  in  1: reset; asynchronous, active-low.
- `play_in`  in  1: level, high while `STATUS_PLAY` is set.
- `clr_in`  in  1: one-cycle pulse; resets buffer position.
- `irqack_in`  in  1: one-cycle pulse from `CMD_IRQACK`.
- `clk_div_in`  in  `DIV_W`: clk cycles per sample, one of the `CLK_DIV_*` values. Held stable while playing.
- `abuf_rindex_out`  out  `RINDEX_BITS`: register index to read.
- `abuf_data_in`  in  24: combinational read data for `abuf_rindex_out`, valid in the same cycle.
- `tick_out`  out  1: one-cycle strobe; `audio0_out`/`audio1_out` are new in this cycle.
- `audio0_out`  out  24: left sample.
- `audio1_out`  out  24: right sample.
- `irq_out`  out  1: sticky buffer-swap interrupt.
- `irq_err_out`  out  1: one-cycle pulse; a swap occurred while `irq_out` was still pending.

## Operation
- FSM states:
  - IDLE: waiting for play.
  - RUN: counting down the sample period.
  - FETCH_L: read left sample.
  - FETCH_R: read right sample.
- Registers: divider counter `cnt`, sample index `idx` (0..`AUDIO_BUFFER_SIZE`-1), buffer select `bsel`, left holding register.
- IDLE → RUN when `play_in` is sampled high. `cnt` loads `eff_div`-1.
  - `eff_div` = max(`clk_div_in`, 4).
- RUN behaviour:
  - `cnt` decrements each cycle.
  - When `cnt`==0, `cnt` reloads `eff_div`-1 and the FSM goes to FETCH_L.
  - The counter keeps running through FETCH_L and FETCH_R, so the sample period is exactly `eff_div` cycles.
- FETCH_L:
  - `abuf_rindex_out` = base + 2·`idx`, where base = `ABUF0_START_INDEX` if `bsel`=0, else `ABUF1_START_INDEX`.
  - `abuf_data_in` is latched into the left holding register.
  - Next state: FETCH_R.
- FETCH_R:
  - `abuf_rindex_out` = base + 2·`idx` + 1.
  - At the clock edge: `audio0_out` ← left holding register, `audio1_out` ← `abuf_data_in`, `tick_out` ← 1 for one cycle.
  - `idx` increments.
  - If `idx` was `AUDIO_BUFFER_SIZE`-1: `idx` ← 0, `bsel` toggles, swap event.
  - Next state: RUN.
- Swap event:
  - If `irq_out`=0, set `irq_out`.
  - If `irq_out`=1, `irq_out` stays 1 and `irq_err_out` pulses.
- `irqack_in` clears `irq_out`. If `irqack_in` and a swap occur in the same cycle, the swap wins: `irq_out` stays 1 and there is no error pulse.
- `play_in` low in any state → IDLE on the next edge.
  - An in-flight fetch is abandoned; no `tick_out` is issued.
  - `idx`, `bsel`, `irq_out` and the audio outputs hold their values.
- `clr_in`:
  - In IDLE: `idx` ← 0, `bsel` ← 0, `audio0_out`/`audio1_out` ← 0, `irq_out` ← 0.
  - In any other state: ignored.
- `abuf_rindex_out` = `ABUF0_START_INDEX` (192) in IDLE and RUN.
- Arithmetic:
  - Index arithmetic is done in `RINDEX_BITS` bits and never wraps, because the maximum value is 319.
  - `cnt` is `DIV_W` bits, unsigned.

## Timing
- Reset values:
  - FSM = IDLE; `cnt`, `idx`, `bsel` = 0.
  - `tick_out`, `irq_out`, `irq_err_out` = 0.
  - `audio0_out`, `audio1_out` = 0.
  - `abuf_rindex_out` = 192.
- Latency:
  - Let E be the edge at which `play_in` is first sampled high.
  - First `tick_out` is high in the cycle following edge E + `eff_div` + 2.
  - Subsequent ticks come every `eff_div` cycles.
- Read timing: left index is driven for exactly 1 cycle, then right index for exactly 1 cycle.
- All outputs are registered except `abuf_rindex_out`, which is decoded from registered state.
- Reset asserted mid-operation forces reset values immediately, without waiting for a clock edge.

## Structure
- Add `ABUF_SAMPLE_W` = 24 and `abuf_player_state_t` (IDLE, RUN, FETCH_L, FETCH_R) to `audioport_pkg`.
- Reuse the existing `ABUF0_START_INDEX`, `ABUF1_START_INDEX` and `RINDEX_BITS`.
- Single module; no sub-module is needed.

## Test plan
- Steady playback:
  - Stimulus: `clk_div_in`=6; ABUF0 reg 192+2k = k, 193+2k = 0x800000+k; `play_in` high.
  - Required: first tick at E+8, ticks every 6 cycles, `audio0_out`/`audio1_out` = 0/0x800000, then 1/0x800001, and so on.
- Buffer swap:
  - Stimulus: play 32 samples.
  - Required: `irq_out` rises with the tick of sample 31; the 33rd read uses indices 256 and 257.
- IRQ error:
  - Stimulus: no `irqack_in` for 64 samples.
  - Required: `irq_err_out` pulses once, with the 64th tick; `irq_out` stays 1.
  - Stimulus: same, but `irqack_in` in the cycle of the second swap.
  - Required: no error pulse.
- Stop during fetch:
  - Stimulus: drop `play_in` while in FETCH_L.
  - Required: no tick; outputs hold; `clr_in` then zeroes `idx`, `bsel`, audio outputs and `irq_out`.
- Divider clamp:
  - Stimulus: `clk_div_in`=2.
  - Required: ticks every 4 cycles.
- Async reset:
  - Stimulus: assert `rst_n` low between clock edges during RUN.
  - Required: all outputs reach reset values immediately.
